tick_clock_generator: RTL and testbench

- Consumer end of the FPGA tick path: takes the single-cycle FPGATick pulse and builds a derived design clock from it.
- The derived clock has a programmable high/low duration counted in ticks.
- Also produces FPGAClock-domain rise/fall enables plus a run/halt and single-step control, so circuit logic can run at the derived rate and be stepped from a debug controller.
- Sits between the tick generator and all synthesized circuit clock consumers.

---
 rtl/tick_clock_generator_pkg.sv | 22 ++
 rtl/tick_step_control.sv | 43 ++++
 rtl/tick_clock_generator.sv | 79 +++++++
 tb/tb_tick_clock_generator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tick_clock_generator_pkg.sv
// Shared definitions for the tick-driven derived clock: level encoding and
// the counter width helper.
package tick_clock_generator_pkg;

   typedef enum logic {
      LOW  = 1'b0,
      HIGH = 1'b1
   } level_t;

   // Smallest width (at least 1) able to hold max(high, low) - 1.
   function automatic int unsigned tick_bits(input int unsigned high_ticks,
                                             input int unsigned low_ticks);
      int unsigned longest;
      int unsigned width;
      longest = (high_ticks > low_ticks) ? high_ticks : low_ticks;
      width   = 1;
      while ((64'd1 << width) < 64'(longest))
         width = width + 1;
      return width;
   endfunction

endpackage

// File: rtl/tick_step_control.sv
// Run/halt gating of the tick stream plus the single-step handshake
// (stepBusy / stepDone).
module tick_step_control
   import tick_clock_generator_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_run,
   input  logic i_step_req,
   input  logic i_at_last,
   output logic o_advance,
   output logic o_step_busy,
   output logic o_step_done
);

   logic r_busy;
   logic r_done;
   logic w_edge;

   assign o_advance   = i_tick & (i_run | r_busy);
   assign w_edge      = o_advance & i_at_last;
   assign o_step_busy = r_busy;
   assign o_step_done = r_done;

   // A request coinciding with a tick only arms the step; that tick is not
   // counted because r_busy is still 0 when o_advance is evaluated.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_busy && w_edge) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end else if (!r_busy && !i_run && i_step_req) begin
            r_busy <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tick_clock_generator.sv
// Builds a derived clock level with programmable high/low tick counts from
// the FPGATick pulse, with rise/fall enables and run/step control.
module tick_clock_generator
   import tick_clock_generator_pkg::*;
#(
   parameter int unsigned highTicks = 1,
   parameter int unsigned lowTicks  = 1,
   parameter int unsigned phase     = 0,
   parameter int unsigned nrOfBits  = 1
) (
   input  logic FPGAClock,
   input  logic FPGAReset,
   input  logic FPGATick,
   input  logic runEnable,
   input  logic stepRequest,
   output logic clockOut,
   output logic risePulse,
   output logic fallPulse,
   output logic stepBusy,
   output logic stepDone
);

   localparam logic [nrOfBits-1:0] HIGH_LAST  = nrOfBits'(highTicks - 1);
   localparam logic [nrOfBits-1:0] LOW_LAST   = nrOfBits'(lowTicks - 1);
   localparam logic [nrOfBits-1:0] PHASE_INIT = nrOfBits'(phase);

   level_t              r_state;
   logic [nrOfBits-1:0] r_count;
   logic                r_rise;
   logic                r_fall;
   logic                w_advance;
   logic                w_at_last;

   assign w_at_last = (r_state == LOW) ? (r_count == LOW_LAST)
                                       : (r_count == HIGH_LAST);

   tick_step_control u_step (
      .i_clk       (FPGAClock),
      .i_rst       (FPGAReset),
      .i_tick      (FPGATick),
      .i_run       (runEnable),
      .i_step_req  (stepRequest),
      .i_at_last   (w_at_last),
      .o_advance   (w_advance),
      .o_step_busy (stepBusy),
      .o_step_done (stepDone)
   );

   always_ff @(posedge FPGAClock or posedge FPGAReset) begin
      if (FPGAReset) begin
         r_state <= LOW;
         r_count <= PHASE_INIT;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_advance) begin
            if (w_at_last) begin
               r_count <= '0;
               if (r_state == LOW) begin
                  r_state <= HIGH;
                  r_rise  <= 1'b1;
               end else begin
                  r_state <= LOW;
                  r_fall  <= 1'b1;
               end
            end else begin
               r_count <= r_count + nrOfBits'(1);
            end
         end
      end
   end

   assign clockOut  = (r_state == HIGH);
   assign risePulse = r_rise;
   assign fallPulse = r_fall;

endmodule

// File: tb/tb_tick_clock_generator.sv
// Four differently configured tick_clock_generator instances driven by shared
// directed and random stimulus, checked against a tick-position model.
module tb_tick_clock_generator;
   import tick_clock_generator_pkg::*;

   localparam int unsigned N = 4;
   localparam int unsigned H0 = 2, L0 = 3, P0 = 0;
   localparam int unsigned H1 = 1, L1 = 1, P1 = 0;
   localparam int unsigned H2 = 2, L2 = 4, P2 = 3;
   localparam int unsigned H3 = 3, L3 = 2, P3 = 0;

   int unsigned hh[N] = '{H0, H1, H2, H3};
   int unsigned ll[N] = '{L0, L1, L2, L3};
   int unsigned pp[N] = '{P0, P1, P2, P3};

   logic clk = 1'b0;
   logic rst, tick, run, req;
   logic [N-1:0] co, rp, fp, sb, sd;

   // Model: position within the derived period; level is high once the
   // position reaches lowTicks.
   int unsigned m_pos[N];
   bit m_busy[N], m_rise[N], m_fall[N], m_done[N];

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   tick_clock_generator #(.highTicks(H0), .lowTicks(L0), .phase(P0),
                          .nrOfBits(tick_bits(H0, L0))) u0 (
      .FPGAClock(clk), .FPGAReset(rst), .FPGATick(tick), .runEnable(run),
      .stepRequest(req), .clockOut(co[0]), .risePulse(rp[0]),
      .fallPulse(fp[0]), .stepBusy(sb[0]), .stepDone(sd[0]));
   tick_clock_generator #(.highTicks(H1), .lowTicks(L1), .phase(P1),
                          .nrOfBits(tick_bits(H1, L1))) u1 (
      .FPGAClock(clk), .FPGAReset(rst), .FPGATick(tick), .runEnable(run),
      .stepRequest(req), .clockOut(co[1]), .risePulse(rp[1]),
      .fallPulse(fp[1]), .stepBusy(sb[1]), .stepDone(sd[1]));
   tick_clock_generator #(.highTicks(H2), .lowTicks(L2), .phase(P2),
                          .nrOfBits(tick_bits(H2, L2))) u2 (
      .FPGAClock(clk), .FPGAReset(rst), .FPGATick(tick), .runEnable(run),
      .stepRequest(req), .clockOut(co[2]), .risePulse(rp[2]),
      .fallPulse(fp[2]), .stepBusy(sb[2]), .stepDone(sd[2]));
   tick_clock_generator #(.highTicks(H3), .lowTicks(L3), .phase(P3),
                          .nrOfBits(tick_bits(H3, L3))) u3 (
      .FPGAClock(clk), .FPGAReset(rst), .FPGATick(tick), .runEnable(run),
      .stepRequest(req), .clockOut(co[3]), .risePulse(rp[3]),
      .fallPulse(fp[3]), .stepBusy(sb[3]), .stepDone(sd[3]));

   task automatic check(input string tag, input int idx, input logic obs,
                        input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s[u%0d] observed=%0b expected=%0b", tag, idx, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pos[i]  = pp[i];
         m_busy[i] = 1'b0;
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         m_done[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit adv, edge_hit;
      for (int i = 0; i < N; i++) begin
         adv       = tick && (run || m_busy[i]);
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (adv) begin
            m_pos[i]  = (m_pos[i] + 1) % (hh[i] + ll[i]);
            m_rise[i] = (m_pos[i] == ll[i]);
            m_fall[i] = (m_pos[i] == 0);
         end
         edge_hit  = m_rise[i] || m_fall[i];
         m_done[i] = 1'b0;
         if (m_busy[i] && adv && edge_hit) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
         end else if (!m_busy[i] && !run && req) begin
            m_busy[i] = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         check("clockOut", i, co[i], m_pos[i] >= ll[i]);
         check("risePulse", i, rp[i], m_rise[i]);
         check("fallPulse", i, fp[i], m_fall[i]);
         check("stepBusy", i, sb[i], m_busy[i]);
         check("stepDone", i, sd[i], m_done[i]);
      end
   endtask

   task automatic cyc(input logic t, input logic r, input logic q);
      tick = t;
      run  = r;
      req  = q;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic async_reset_pulse();
      #3 rst = 1'b1;
      #1 model_reset();
      check_all();
      #1 rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      tick = 1'b0;
      run  = 1'b1;
      req  = 1'b0;
      #12;
      model_reset();
      check_all();
      rst = 1'b0;

      // Free-running, tick every cycle
      for (int k = 1; k <= 20; k++) begin
         cyc(1'b1, 1'b1, 1'b0);
         if (k == 3 || k == 8 || k == 13) check("u0_rise_cycle", 0, rp[0], 1'b1);
         if (k == 5 || k == 10) check("u0_fall_cycle", 0, fp[0], 1'b1);
      end
      // Sparse ticks
      for (int k = 0; k < 16; k++) cyc(k % 4 == 0, 1'b1, 1'b0);
      // Halted: idle ticks, then single steps
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0);
      // Requests while busy are ignored
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0);
      // Request coincident with a tick
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0);
      // runEnable rising during a step, then falling mid-half
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0);

      // Randomized segments
      for (int s = 0; s < 24; s++) begin
         logic seg_run;
         seg_run = ($urandom_range(0, 2) == 0);
         for (int k = 0; k < 20; k++)
            cyc(1'($urandom_range(0, 1)), seg_run, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) async_reset_pulse();
      end

      // Async reset mid-HIGH of u3 with a step pending
      async_reset_pulse();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check("u3_step_rise", 3, rp[3], 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      check("u3_high_before_rst", 3, co[3], 1'b1);
      check("u3_busy_before_rst", 3, sb[3], 1'b1);
      #3 rst = 1'b1;
      #1 model_reset();
      check_all();
      check("u3_rst_clock", 3, co[3], 1'b0);
      @(posedge clk);
      #1 check_all();
      check("u3_rst_no_done", 3, sd[3], 1'b0);
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         cyc(1'b1, 1'b1, 1'b0);
         if (k == 2) check("u3_rise_after_rst", 3, rp[3], 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
